telemetry_rx: RTL

TELEMETRY_RX -- requirements
Module: telemetry_rx

---
 rtl/telemetry_rx.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/telemetry_rx.sv
// UART 8N1 receiver feeding an eBike telemetry packet parser (AA 55 + three 12-bit readings).
// Outputs update atomically once a complete, well-formed packet has been received.
module telemetry_rx #(
  parameter int BAUD_DIV = 2604
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic [11:0] batt,
  output logic [11:0] curr,
  output logic [11:0] torque,
  output logic        vld,
  output logic        frm_err,
  output logic        pkt_err
);

  localparam int CW = $clog2(BAUD_DIV + 1);
  localparam logic [CW-1:0] HALF_BIT = CW'(BAUD_DIV / 2);
  localparam logic [CW-1:0] FULL_BIT = CW'(BAUD_DIV - 1);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic [1:0] P_HUNT_AA = 2'd0;
  localparam logic [1:0] P_HUNT_55 = 2'd1;
  localparam logic [1:0] P_PAYLOAD = 2'd2;

  logic          rx_meta, rx_sync, rx_prev;
  logic [1:0]    rx_state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    rx_byte;
  logic          byte_rdy;

  logic [1:0]    p_state;
  logic [2:0]    idx;
  logic [11:0]   sh_batt;
  logic [11:0]   sh_curr;
  logic [3:0]    sh_torque_hi;

  // NOTE: the synchronizer resets to 1 (idle line) so reset release never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
      rx_meta <= RX;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= RX_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      rx_byte  <= '0;
      byte_rdy <= 1'b0;
      frm_err  <= 1'b0;
    end else begin
      byte_rdy <= 1'b0;
      frm_err  <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_sync) begin
            rx_state <= RX_START;
            baud_cnt <= HALF_BIT;
          end
        end
        RX_START: begin
          if (baud_cnt != '0) begin
            baud_cnt <= baud_cnt - CW'(1);
          end else if (rx_sync) begin
            rx_state <= RX_IDLE;  // glitch: line back high at mid start bit
          end else begin
            rx_state <= RX_DATA;
            baud_cnt <= FULL_BIT;
            bit_cnt  <= '0;
          end
        end
        RX_DATA: begin
          if (baud_cnt != '0) begin
            baud_cnt <= baud_cnt - CW'(1);
          end else begin
            rx_byte  <= {rx_sync, rx_byte[7:1]};
            baud_cnt <= FULL_BIT;
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) rx_state <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (baud_cnt != '0) begin
            baud_cnt <= baud_cnt - CW'(1);
          end else begin
            byte_rdy <= rx_sync;
            frm_err  <= !rx_sync;
            rx_state <= RX_IDLE;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // Payload lands in shadow registers; outputs change only on the final byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_state      <= P_HUNT_AA;
      idx          <= '0;
      sh_batt      <= '0;
      sh_curr      <= '0;
      sh_torque_hi <= '0;
      batt         <= '0;
      curr         <= '0;
      torque       <= '0;
      vld          <= 1'b0;
      pkt_err      <= 1'b0;
    end else begin
      vld     <= 1'b0;
      pkt_err <= 1'b0;
      if (frm_err) begin
        p_state <= P_HUNT_AA;
      end else if (byte_rdy) begin
        case (p_state)
          P_HUNT_AA: begin
            if (rx_byte == 8'hAA) p_state <= P_HUNT_55;
          end
          P_HUNT_55: begin
            if (rx_byte == 8'h55) begin
              p_state <= P_PAYLOAD;
              idx     <= '0;
            end else if (rx_byte != 8'hAA) begin
              p_state <= P_HUNT_AA;
            end
          end
          P_PAYLOAD: begin
            if (!idx[0] && rx_byte[7:4] != 4'h0) begin
              pkt_err <= 1'b1;
              p_state <= P_HUNT_AA;
            end else begin
              idx <= idx + 3'd1;
              case (idx)
                3'd0: sh_batt[11:8]  <= rx_byte[3:0];
                3'd1: sh_batt[7:0]   <= rx_byte;
                3'd2: sh_curr[11:8]  <= rx_byte[3:0];
                3'd3: sh_curr[7:0]   <= rx_byte;
                3'd4: sh_torque_hi   <= rx_byte[3:0];
                3'd5: begin
                  batt    <= sh_batt;
                  curr    <= sh_curr;
                  torque  <= {sh_torque_hi, rx_byte};
                  vld     <= 1'b1;
                  p_state <= P_HUNT_AA;
                end
                default: p_state <= P_HUNT_AA;
              endcase
            end
          end
          default: p_state <= P_HUNT_AA;
        endcase
      end
    end
  end

endmodule
